// File: rtl/game_countdown.sv
// Round timer for a game: counts START_SECONDS down at TICKS_PER_SEC clocks per
// second, with pause, bonus time, victory on all enemies dead and a sticky timeout.
module game_countdown #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int START_SECONDS = 60,
  parameter int N_ENEMIES     = 7,
  parameter int SEC_W         = 10,
  parameter int BONUS_SECONDS = 5,
  parameter int MAX_SECONDS   = 999,
  parameter int WARN_SECONDS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic [N_ENEMIES-1:0] enemy_dead,
  input  logic                 bonus,
  output logic [SEC_W-1:0]     seconds,
  output logic                 tick,
  output logic                 running,
  output logic                 low_time,
  output logic                 game_over,
  output logic                 victory
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SEC_W-1:0] SEC_START = SEC_W'(START_SECONDS);
  localparam logic [SEC_W:0]   EXT_ONE   = (SEC_W+1)'(1);
  localparam logic [SEC_W:0]   EXT_BONUS = (SEC_W+1)'(BONUS_SECONDS);
  localparam logic [SEC_W:0]   EXT_MAX   = (SEC_W+1)'(MAX_SECONDS);
  localparam logic [SEC_W:0]   EXT_WARN  = (SEC_W+1)'(WARN_SECONDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PAUSED  = 3'd2;
  localparam logic [2:0] S_TIMEOUT = 3'd3;
  localparam logic [2:0] S_WIN     = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [SEC_W-1:0] r_seconds;
  logic             r_tick;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [SEC_W-1:0] w_seconds_nxt;
  logic             w_tick_nxt;

  logic             w_tick_due;
  logic             w_all_dead;
  logic [SEC_W:0]   w_sec_base;
  logic [SEC_W:0]   w_sec_sum;
  logic [SEC_W:0]   w_sec_sat;

  assign w_tick_due = (r_count == CNT_LAST);
  assign w_all_dead = &enemy_dead;

  // One extra bit keeps decrement-plus-bonus from wrapping before saturation.
  assign w_sec_base = (w_tick_due && (r_seconds != '0)) ? ({1'b0, r_seconds} - EXT_ONE)
                                                        : {1'b0, r_seconds};
  assign w_sec_sum  = w_sec_base + (bonus ? EXT_BONUS : '0);
  assign w_sec_sat  = (w_sec_sum > EXT_MAX) ? EXT_MAX : w_sec_sum;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_seconds_nxt = r_seconds;
    w_tick_nxt    = 1'b0;
    if (start) begin
      w_state_nxt   = S_RUN;
      w_count_nxt   = '0;
      w_seconds_nxt = SEC_START;
    end else begin
      case (r_state)
        S_IDLE, S_TIMEOUT, S_WIN: ;
        S_RUN: begin
          if (w_all_dead) begin
            w_state_nxt = S_WIN;
          end else if (pause) begin
            w_state_nxt = S_PAUSED;
          end else begin
            w_count_nxt   = w_tick_due ? '0 : (r_count + CNT_ONE);
            w_seconds_nxt = w_sec_sat[SEC_W-1:0];
            w_tick_nxt    = w_tick_due;
            if (w_tick_due && (w_sec_sat == '0)) w_state_nxt = S_TIMEOUT;
          end
        end
        S_PAUSED: if (!pause) w_state_nxt = S_RUN;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_seconds <= SEC_START;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_seconds <= w_seconds_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign seconds   = r_seconds;
  assign tick      = r_tick;
  assign running   = (r_state == S_RUN);
  assign game_over = (r_state == S_TIMEOUT);
  assign victory   = (r_state == S_WIN);
  assign low_time  = ((r_state == S_RUN) || (r_state == S_PAUSED)) &&
                     (r_seconds != '0) && ({1'b0, r_seconds} <= EXT_WARN);

endmodule

// File: tb/tb_game_countdown.sv
// Self-checking bench for game_countdown: directed scenarios plus a randomized run
// compared against a seconds/phase model of the round rules.
module tb_game_countdown;

  localparam int TPS   = 4;
  localparam int START = 3;
  localparam int NE    = 3;
  localparam int SEC_W = 10;
  localparam int BONUS = 2;
  localparam int MAXS  = 5;
  localparam int WARN  = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             bonus = 1'b0;
  logic [NE-1:0]    enemy_dead = '0;
  logic [SEC_W-1:0] seconds;
  logic             tick, running, low_time, game_over, victory;

  int checks   = 0;
  int failures = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_OVER, M_WON} mode_t;
  mode_t m_mode;
  int    m_sec;
  int    m_phase;
  bit    m_tick;

  always #5 clk = ~clk;

  game_countdown #(
    .TICKS_PER_SEC(TPS), .START_SECONDS(START), .N_ENEMIES(NE), .SEC_W(SEC_W),
    .BONUS_SECONDS(BONUS), .MAX_SECONDS(MAXS), .WARN_SECONDS(WARN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .enemy_dead(enemy_dead),
    .bonus(bonus), .seconds(seconds), .tick(tick), .running(running),
    .low_time(low_time), .game_over(game_over), .victory(victory)
  );

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_sec   = START;
    m_phase = 0;
    m_tick  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    m_tick = 1'b0;
    if (rst) begin
      model_reset();
    end else if (start) begin
      m_mode  = M_RUN;
      m_sec   = START;
      m_phase = 0;
    end else if (m_mode == M_RUN) begin
      if (enemy_dead == '1) m_mode = M_WON;
      else if (pause) m_mode = M_PAUSED;
      else begin
        m_phase++;
        if (m_phase == TPS) begin
          m_phase = 0;
          m_sec--;
          m_tick = 1'b1;
        end
        if (bonus) m_sec += BONUS;
        if (m_sec > MAXS) m_sec = MAXS;
        if (m_tick && m_sec == 0) m_mode = M_OVER;
      end
    end else if (m_mode == M_PAUSED && !pause) begin
      m_mode = M_RUN;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (seconds !== SEC_W'(START)) begin
      failures++;
      $display("FAIL reset_seconds: got %0d expected %0d", seconds, START);
    end
    checks++;
    if ({tick, running, low_time, game_over, victory} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {tick, running, low_time, game_over, victory});
    end
    cycle();
    cycle();
    rst = 1'b0;
    pause = 1'b1; bonus = 1'b1; enemy_dead = '1;
    cycle();
    checks++;
    if ({seconds, running, victory} !== {SEC_W'(START), 2'b00}) begin
      failures++;
      $display("FAIL idle_ignores_inputs: got sec=%0d run=%b vic=%b expected sec=%0d run=0 vic=0",
               seconds, running, victory, START);
    end
    pause = 1'b0; bonus = 1'b0; enemy_dead = '0;
    pulse_start();
    checks++;
    if ({seconds, running, low_time} !== {SEC_W'(START), 2'b10}) begin
      failures++;
      $display("FAIL start_after_reset: got sec=%0d run=%b low=%b expected sec=%0d run=1 low=0",
               seconds, running, low_time, START);
    end
  endtask

  task automatic test_timeout();
    int nticks = 0;
    logic [SEC_W-1:0] exp_sec;
    logic exp_tick, exp_go, exp_low;
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp_sec  = SEC_W'(START - k / TPS);
      exp_tick = (k % TPS == 0);
      exp_go   = (k == 12);
      exp_low  = !exp_go && (exp_sec >= 1) && (exp_sec <= SEC_W'(WARN));
      if (tick === 1'b1) nticks++;
      checks++;
      if ({seconds, tick, game_over, low_time} !== {exp_sec, exp_tick, exp_go, exp_low}) begin
        failures++;
        $display("FAIL timeout_cycle%0d: got sec=%0d tick=%b go=%b low=%b expected sec=%0d tick=%b go=%b low=%b",
                 k, seconds, tick, game_over, low_time, exp_sec, exp_tick, exp_go, exp_low);
      end
    end
    pause = 1'b1; bonus = 1'b1; enemy_dead = '1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if ({seconds, tick, running, game_over, victory} !== {SEC_W'(0), 4'b0010}) begin
        failures++;
        $display("FAIL timeout_sticky%0d: got sec=%0d tick=%b run=%b go=%b vic=%b expected sec=0 go=1 others 0",
                 k, seconds, tick, running, game_over, victory);
      end
    end
    pause = 1'b0; bonus = 1'b0; enemy_dead = '0;
    checks++;
    if (nticks != 3) begin
      failures++;
      $display("FAIL timeout_tick_count: got %0d expected 3", nticks);
    end
  endtask

  task automatic test_victory();
    pulse_start();
    repeat (2 * TPS) cycle();
    enemy_dead = '1;
    cycle();
    checks++;
    if ({seconds, victory, game_over, running} !== {SEC_W'(1), 3'b100}) begin
      failures++;
      $display("FAIL victory_enter: got sec=%0d vic=%b go=%b run=%b expected sec=1 vic=1 go=0 run=0",
               seconds, victory, game_over, running);
    end
    repeat (6) cycle();
    checks++;
    if ({seconds, victory, game_over} !== {SEC_W'(1), 2'b10}) begin
      failures++;
      $display("FAIL victory_sticky: got sec=%0d vic=%b go=%b expected sec=1 vic=1 go=0",
               seconds, victory, game_over);
    end
    enemy_dead = '0;
    pulse_start();
    checks++;
    if ({seconds, victory, running} !== {SEC_W'(START), 2'b01}) begin
      failures++;
      $display("FAIL victory_restart: got sec=%0d vic=%b run=%b expected sec=%0d vic=0 run=1",
               seconds, victory, running, START);
    end
    // All enemies die on the very cycle the last second would expire.
    repeat (3 * TPS - 1) cycle();
    enemy_dead = '1;
    cycle();
    enemy_dead = '0;
    checks++;
    if ({seconds, victory, game_over} !== {SEC_W'(1), 2'b10}) begin
      failures++;
      $display("FAIL victory_beats_timeout: got sec=%0d vic=%b go=%b expected sec=1 vic=1 go=0",
               seconds, victory, game_over);
    end
  endtask

  task automatic test_pause();
    logic exp_tick;
    logic [SEC_W-1:0] exp_sec;
    pulse_start();
    repeat (2) cycle();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bonus = (i == 0);
      enemy_dead = (i >= 3 && i < 8) ? '1 : '0;
      cycle();
      checks++;
      if ({seconds, running, tick, victory} !== {SEC_W'(START), 3'b000}) begin
        failures++;
        $display("FAIL pause_hold%0d: got sec=%0d run=%b tick=%b vic=%b expected sec=%0d others 0",
                 i, seconds, running, tick, victory, START);
      end
    end
    bonus = 1'b0; enemy_dead = '0; pause = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      cycle();
      exp_tick = (j == 3);
      exp_sec  = (j == 3) ? SEC_W'(START - 1) : SEC_W'(START);
      checks++;
      if ({seconds, tick, running} !== {exp_sec, exp_tick, 1'b1}) begin
        failures++;
        $display("FAIL pause_resume%0d: got sec=%0d tick=%b run=%b expected sec=%0d tick=%b run=1",
                 j, seconds, tick, running, exp_sec, exp_tick);
      end
    end
  endtask

  task automatic test_bonus();
    pulse_start();
    bonus = 1'b1;
    cycle();
    checks++;
    if (seconds !== SEC_W'(MAXS)) begin
      failures++;
      $display("FAIL bonus_first: got %0d expected %0d", seconds, MAXS);
    end
    bonus = 1'b0;
    cycle();
    bonus = 1'b1;
    cycle();
    bonus = 1'b0;
    checks++;
    if (seconds !== SEC_W'(MAXS)) begin
      failures++;
      $display("FAIL bonus_saturate: got %0d expected %0d", seconds, MAXS);
    end
    pulse_start();
    repeat (3 * TPS - 1) cycle();
    bonus = 1'b1;
    cycle();
    bonus = 1'b0;
    checks++;
    if ({seconds, tick, game_over, running} !== {SEC_W'(2), 3'b101}) begin
      failures++;
      $display("FAIL bonus_on_last_tick: got sec=%0d tick=%b go=%b run=%b expected sec=2 tick=1 go=0 run=1",
               seconds, tick, game_over, running);
    end
  endtask

  task automatic test_reset_mid_round();
    int bad = 0;
    pulse_start();
    repeat (TPS) cycle();
    checks++;
    if (seconds !== SEC_W'(START - 1)) begin
      failures++;
      $display("FAIL midreset_precondition: got %0d expected %0d", seconds, START - 1);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({seconds, tick, running, low_time, game_over, victory} !== {SEC_W'(START), 5'b0}) begin
      failures++;
      $display("FAIL midreset_async: got sec=%0d tick=%b run=%b low=%b go=%b vic=%b expected sec=%0d others 0",
               seconds, tick, running, low_time, game_over, victory, START);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick !== 1'b0 || running !== 1'b0 || seconds !== SEC_W'(START)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_idle: got %0d bad idle cycles expected 0", bad);
    end
    pulse_start();
    checks++;
    if ({seconds, running} !== {SEC_W'(START), 1'b1}) begin
      failures++;
      $display("FAIL midreset_restart: got sec=%0d run=%b expected sec=%0d run=1",
               seconds, running, START);
    end
  endtask

  task automatic test_random();
    logic [SEC_W+4:0] exp_vec, got_vec;
    logic exp_low;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
      end
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      bonus = ($urandom_range(0, 7) == 0);
      enemy_dead = ($urandom_range(0, 29) == 0) ? '1 : NE'($urandom_range(0, 6));
      cycle();
      exp_low = (m_mode == M_RUN || m_mode == M_PAUSED) && m_sec > 0 && m_sec <= WARN;
      exp_vec = {SEC_W'(m_sec), m_tick, m_mode == M_RUN, exp_low, m_mode == M_OVER, m_mode == M_WON};
      got_vec = {seconds, tick, running, low_time, game_over, victory};
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL random_cycle%0d: got sec=%0d flags=%b expected sec=%0d flags=%b",
                 n, got_vec[SEC_W+4:5], got_vec[4:0], exp_vec[SEC_W+4:5], exp_vec[4:0]);
      end
    end
    start = 1'b0; pause = 1'b0; bonus = 1'b0; enemy_dead = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timeout();
    test_victory();
    test_pause();
    test_bonus();
    test_reset_mid_round();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000: clk cycles per game second.
REQ-002 SHALL have parameter START_SECONDS, default 60: value loaded at round start.
REQ-003 SHALL have parameter N_ENEMIES, default 7: number of enemy-dead flags.
REQ-004 SHALL have parameter SEC_W, default 10: width of the seconds counter.
REQ-005 SHALL have parameter BONUS_SECONDS, default 5: seconds added per bonus pulse.
REQ-006 SHALL have parameter MAX_SECONDS, default 999: saturation ceiling; MAX_SECONDS < 2^SEC_W and START_SECONDS <= MAX_SECONDS.
REQ-007 SHALL have parameter WARN_SECONDS, default 10: low-time threshold.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-010 SHALL have port start  input  1  one-cycle pulse; begins or restarts a round.
REQ-011 SHALL have port pause  input  1  level; freezes the countdown while high.
REQ-012 SHALL have port enemy_dead  input  N_ENEMIES  one bit per enemy, 1 = dead.
REQ-013 SHALL have port bonus  input  1  one-cycle pulse; adds BONUS_SECONDS.
REQ-014 SHALL have port seconds  output  SEC_W  remaining seconds, registered.
REQ-015 SHALL have port tick  output  1  one-cycle pulse on each seconds decrement.
REQ-016 SHALL have port running  output  1  high in state RUN only.
REQ-017 SHALL have port low_time  output  1  high in RUN/PAUSED while 0 < seconds <= WARN_SECONDS.
REQ-018 SHALL have port game_over  output  1  high in state TIMEOUT.
REQ-019 SHALL have port victory  output  1  high in state WIN.

Function
REQ-020 SHALL implement states IDLE, RUN, PAUSED, TIMEOUT and WIN; any unencoded state SHALL go to IDLE on the next clk.
REQ-021 SHALL keep a prescaler count, 0..TICKS_PER_SEC-1, that advances by 1 per clk only in RUN.
REQ-022 start in any state SHALL, on the next edge: enter RUN; load seconds=START_SECONDS; clear count, game_over and victory.
REQ-023 Priority within one cycle SHALL be: start > victory check > pause > bonus/tick.
REQ-024 In RUN with enemy_dead all ones, the block SHALL enter WIN on the next edge and hold seconds and count; this takes priority over a coincident timeout.
REQ-025 In RUN with pause=1, the block SHALL enter PAUSED; count and seconds hold, and bonus is ignored.
REQ-026 In PAUSED with pause=0, the block SHALL return to RUN and resume from the held count; victory is not evaluated while in PAUSED.
REQ-027 In RUN with count==TICKS_PER_SEC-1, the block SHALL set count=0, decrement seconds and pulse tick for exactly one cycle.
REQ-028 A decrement from seconds==1 with no coincident bonus SHALL give seconds=0 and enter TIMEOUT; game_over SHALL rise in the same edge.
REQ-029 bonus in RUN SHALL add BONUS_SECONDS to seconds, saturating at MAX_SECONDS; arithmetic SHALL use SEC_W+1 bits so nothing wraps.
REQ-030 A bonus coincident with a tick SHALL give seconds = min(seconds-1+BONUS_SECONDS, MAX_SECONDS); no timeout occurs when the result is > 0.
REQ-031 TIMEOUT and WIN SHALL be sticky; they leave only on start or rst, and all other inputs are ignored there.
REQ-032 IDLE SHALL ignore pause, bonus and enemy_dead.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, count=0, seconds=START_SECONDS and tick=running=low_time=game_over=victory=0, independent of clk.
REQ-034 rst asserted mid-round SHALL abort the round; the block does not count after release until start is pulsed.
REQ-035 The first rising clk edge after rst deasserts SHALL be a normal evaluation edge.

Verification
Bench parameters: TICKS_PER_SEC=4, START_SECONDS=3, N_ENEMIES=3, BONUS_SECONDS=2, MAX_SECONDS=5, WARN_SECONDS=1.
REQ-036 Timeout: pulse start, hold inputs low -> tick every 4 cycles; seconds reads 2, 1, 0; game_over=1 on the 12th RUN cycle and held; tick pulses 3 times.
REQ-037 Victory: set enemy_dead=3'b111 after the second tick (seconds=1) -> victory=1 next edge, seconds stays 1, game_over stays 0; a later start gives seconds=3, victory=0.
REQ-038 Pause: assert pause at count=2 for 10 cycles, then release -> seconds unchanged during pause; the next tick comes exactly 2 RUN cycles after release.
REQ-039 Bonus saturation: pulse bonus twice at seconds=3 -> seconds=5 then stays 5; bonus coincident with the final tick at seconds=1 -> seconds=2, no game_over.
REQ-040 Reset mid-round: assert rst at seconds=2 -> outputs take reset values immediately with no clk; after release, 20 idle cycles give no tick and seconds=3.
